// File: rtl/posit_mult_arbiter_8bit_pkg.sv
// Shared definitions for the two-requester posit multiplier arbiter.
// Holds the layout of the 21-bit product word, the requester identifiers,
// the response-register state encoding and the posit decode helper used by
// the combinational multiplier.
//
// Product word layout:
//   [20:19] flags  (00 normal, 01 zero, 10 infinity/NaR, 11 NaN from inf*0)
//   [18]    sign
//   [17:13] exponent, biased by 15
//   [12:0]  fraction, left-aligned, hidden leading one not stored
package posit_mult_arbiter_8bit_pkg;

  localparam int POSIT_W  = 8;
  localparam int RES_W    = 21;

  localparam int FLAG_HI  = 20;
  localparam int FLAG_LO  = 19;
  localparam int SIGN     = 18;
  localparam int EXP_HI   = 17;
  localparam int EXP_LO   = 13;
  localparam int FRAC_HI  = 12;

  localparam int EXP_BIAS = 15;

  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;

  localparam logic [1:0] FLAG_NORMAL = 2'b00;
  localparam logic [1:0] FLAG_ZERO   = 2'b01;
  localparam logic [1:0] FLAG_INF    = 2'b10;
  localparam logic [1:0] FLAG_NAN    = 2'b11;

  localparam logic [POSIT_W-1:0] POSIT_ZERO = 8'h00;
  localparam logic [POSIT_W-1:0] POSIT_NAR  = 8'h80;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arbState_e;

  // Decoded posit (es = 0): value = (-1)^sign * 2^scale * mant/32.
  // scale is two's complement in [-6, 6]; mant carries the hidden one in bit 5.
  typedef struct packed {
    logic       sign;
    logic [4:0] scale;
    logic [5:0] mant;
  } positDec_t;

  // Decodes a non-special 8-bit posit with no exponent field. Negative
  // values are two's-complemented first, then the regime run is measured
  // from bit 6 downward; everything after the run and its terminating bit
  // is fraction. Zero and NaR are not meaningful here and are handled by
  // the caller.
  function automatic positDec_t decodePosit(input logic [POSIT_W-1:0] p);
    positDec_t  d;
    logic [6:0] body;
    logic [6:0] shifted;
    logic       r0;
    logic       stop;
    logic [3:0] run;
    logic [4:0] run5;

    body = 7'(p[7] ? (~p + 8'd1) : p);
    r0   = body[6];
    run  = 4'd0;
    stop = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!stop && (body[i] == r0)) begin
        run = run + 4'd1;
      end else begin
        stop = 1'b1;
      end
    end

    shifted = body << (run + 4'd1);
    run5    = {1'b0, run};

    d.sign  = p[7];
    d.scale = r0 ? (run5 - 5'd1) : (5'd0 - run5);
    d.mant  = {1'b1, 5'(shifted >> 2)};
    return d;
  endfunction

endpackage

// File: rtl/posit_mult_arbiter_8bit_mult.sv
// posit_mult_8bit_to_16bit: purely combinational multiplier for two 8-bit
// posits (es = 0). The product is expressed in an exact unrounded wide
// format so no precision is lost: two flag bits, a sign, a biased 5-bit
// exponent and a 13-bit left-aligned fraction.
//
// Ports:
//   left_i   [7:0]   first posit operand
//   right_i  [7:0]   second posit operand
//   result_o [20:0]  product word (layout in the package)
module posit_mult_8bit_to_16bit
  import posit_mult_arbiter_8bit_pkg::*;
(
  input  logic [POSIT_W-1:0] left_i,
  input  logic [POSIT_W-1:0] right_i,
  output logic [RES_W-1:0]   result_o
);

  positDec_t   decLeft;
  positDec_t   decRight;
  logic [11:0] mantProd;
  logic [5:0]  scaleSum;
  logic [5:0]  expBiased;
  logic [10:0] fracNorm;
  logic        leftNar;
  logic        rightNar;
  logic        leftZero;
  logic        rightZero;

  assign decLeft  = decodePosit(left_i);
  assign decRight = decodePosit(right_i);

  // Mantissas are 1.xxxxx, so the product lies in [1, 4). When bit 11 is
  // set the product is >= 2 and needs a one-place normalising shift.
  always_comb begin
    mantProd  = 12'(decLeft.mant) * 12'(decRight.mant);
    scaleSum  = {decLeft.scale[4], decLeft.scale} + {decRight.scale[4], decRight.scale};
    expBiased = scaleSum + {5'd0, mantProd[11]} + 6'(EXP_BIAS);
    if (mantProd[11]) begin
      fracNorm = mantProd[10:0];
    end else begin
      fracNorm = {mantProd[9:0], 1'b0};
    end
  end

  assign leftNar   = (left_i == POSIT_NAR);
  assign rightNar  = (right_i == POSIT_NAR);
  assign leftZero  = (left_i == POSIT_ZERO);
  assign rightZero = (right_i == POSIT_ZERO);

  // Specials take priority over the arithmetic path; inf*0 is the only
  // combination that produces the NaN flag.
  always_comb begin
    result_o = '0;
    if ((leftNar && rightZero) || (rightNar && leftZero)) begin
      result_o[FLAG_HI:FLAG_LO] = FLAG_NAN;
    end else if (leftNar || rightNar) begin
      result_o[FLAG_HI:FLAG_LO] = FLAG_INF;
    end else if (leftZero || rightZero) begin
      result_o[FLAG_HI:FLAG_LO] = FLAG_ZERO;
    end else begin
      result_o[FLAG_HI:FLAG_LO] = FLAG_NORMAL;
      result_o[SIGN]            = decLeft.sign ^ decRight.sign;
      result_o[EXP_HI:EXP_LO]   = expBiased[4:0];
      result_o[FRAC_HI:0]       = {fracNorm, 2'b00};
    end
  end

endmodule

// File: rtl/posit_mult_arbiter_8bit.sv
// posit_mult_arbiter_8bit: shares one combinational posit multiplier
// between two requesters with round-robin arbitration and a single
// registered response slot that supports one result per cycle.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   a_valid_i / a_ready_o       requester A handshake
//   a_left_i, a_right_i [7:0]   requester A operands
//   b_valid_i / b_ready_o       requester B handshake
//   b_left_i, b_right_i [7:0]   requester B operands
//   resp_valid_o / resp_ready_i response handshake
//   resp_id_o                   response owner (0 = A, 1 = B)
//   resp_result_o [20:0]        product word
//   a_count_o, b_count_o        saturating delivered-response counters
module posit_mult_arbiter_8bit
  import posit_mult_arbiter_8bit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               a_valid_i,
  output logic               a_ready_o,
  input  logic [POSIT_W-1:0] a_left_i,
  input  logic [POSIT_W-1:0] a_right_i,
  input  logic               b_valid_i,
  output logic               b_ready_o,
  input  logic [POSIT_W-1:0] b_left_i,
  input  logic [POSIT_W-1:0] b_right_i,
  output logic               resp_valid_o,
  input  logic               resp_ready_i,
  output logic               resp_id_o,
  output logic [RES_W-1:0]   resp_result_o,
  output logic [CNT_W-1:0]   a_count_o,
  output logic [CNT_W-1:0]   b_count_o
);

  arbState_e          state_q, state_d;
  logic [RES_W-1:0]   respResult_q, respResult_d;
  logic               respId_q, respId_d;
  logic               lastId_q, lastId_d;
  logic [CNT_W-1:0]   aCount_q, aCount_d;
  logic [CNT_W-1:0]   bCount_q, bCount_d;
  logic               started_q;

  logic               canAccept;
  logic               grantA;
  logic               grantB;
  logic               transfer;
  logic               respHandshake;
  logic [POSIT_W-1:0] mulLeft;
  logic [POSIT_W-1:0] mulRight;
  logic [RES_W-1:0]   mulResult;

  // Grant depends only on valids and the pointer, never on ready, so there
  // is no combinational loop through the requesters. started_q keeps both
  // readies low in reset and for the first cycle after release.
  always_comb begin
    canAccept     = (state_q == ST_EMPTY) || resp_ready_i;
    grantA        = a_valid_i && (!b_valid_i || (lastId_q == ID_B));
    grantB        = b_valid_i && !grantA;
    a_ready_o     = started_q && canAccept && grantA;
    b_ready_o     = started_q && canAccept && grantB;
    transfer      = a_ready_o || b_ready_o;
    respHandshake = (state_q == ST_FULL) && resp_ready_i;
  end

  assign mulLeft  = grantB ? b_left_i  : a_left_i;
  assign mulRight = grantB ? b_right_i : a_right_i;

  posit_mult_8bit_to_16bit uMult (
    .left_i   (mulLeft),
    .right_i  (mulRight),
    .result_o (mulResult)
  );

  // A new transfer always refills the slot, even in the same cycle the old
  // response leaves, which gives back-to-back throughput.
  always_comb begin
    state_d      = state_q;
    respResult_d = respResult_q;
    respId_d     = respId_q;
    lastId_d     = lastId_q;
    if (transfer) begin
      state_d      = ST_FULL;
      respResult_d = mulResult;
      respId_d     = grantB ? ID_B : ID_A;
      lastId_d     = grantB ? ID_B : ID_A;
    end else if (respHandshake) begin
      state_d = ST_EMPTY;
    end
  end

  // Counters follow the owner of the response leaving this cycle and stop
  // at all-ones.
  always_comb begin
    aCount_d = aCount_q;
    bCount_d = bCount_q;
    if (respHandshake) begin
      if ((respId_q == ID_A) && (aCount_q != {CNT_W{1'b1}})) begin
        aCount_d = aCount_q + CNT_W'(1);
      end
      if ((respId_q == ID_B) && (bCount_q != {CNT_W{1'b1}})) begin
        bCount_d = bCount_q + CNT_W'(1);
      end
    end
  end

  // lastId resets to B so that A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      respResult_q <= '0;
      respId_q     <= ID_A;
      lastId_q     <= ID_B;
      aCount_q     <= '0;
      bCount_q     <= '0;
      started_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      respResult_q <= respResult_d;
      respId_q     <= respId_d;
      lastId_q     <= lastId_d;
      aCount_q     <= aCount_d;
      bCount_q     <= bCount_d;
      started_q    <= 1'b1;
    end
  end

  assign resp_valid_o  = (state_q == ST_FULL);
  assign resp_id_o     = respId_q;
  assign resp_result_o = respResult_q;
  assign a_count_o     = aCount_q;
  assign b_count_o     = bCount_q;

endmodule

// File: tb/tb_posit_mult_arbiter_8bit.sv
// Directed bench for posit_mult_arbiter_8bit. A behavioural model tracks
// the arbiter pointer, slot occupancy and counters; expected products come
// from a real-number posit evaluation and wait in a queue until the DUT
// presents them.
module tb_posit_mult_arbiter_8bit;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             clk;
  logic             rst_n;
  logic             aValid, aReady, bValid, bReady;
  logic [7:0]       aLeft, aRight, bLeft, bRight;
  logic             respValid, respReady, respId;
  logic [20:0]      respResult;
  logic [CNT_W-1:0] aCount, bCount;

  int nChecks;
  int nFail;

  logic [21:0]      expQ[$];
  logic             mFull;
  logic             mLastId;
  logic [CNT_W-1:0] mCntA, mCntB;

  posit_mult_arbiter_8bit #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a_valid_i     (aValid),
    .a_ready_o     (aReady),
    .a_left_i      (aLeft),
    .a_right_i     (aRight),
    .b_valid_i     (bValid),
    .b_ready_o     (bReady),
    .b_left_i      (bLeft),
    .b_right_i     (bRight),
    .resp_valid_o  (respValid),
    .resp_ready_i  (respReady),
    .resp_id_o     (respId),
    .resp_result_o (respResult),
    .a_count_o     (aCount),
    .b_count_o     (bCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Magnitude of an es=0 posit, straight from the regime/fraction definition.
  function automatic real positMag(input logic [7:0] p);
    logic [7:0] mag;
    logic       r;
    int         k;
    int         idx;
    real        v;
    real        w;
    mag = p[7] ? (8'd0 - p) : p;
    r   = mag[6];
    k   = r ? -1 : 0;
    idx = 6;
    while (idx >= 0) begin
      if (mag[idx] != r) break;
      k = r ? k + 1 : k - 1;
      idx--;
    end
    idx--;
    v = 1.0;
    w = 0.5;
    while (idx >= 0) begin
      if (mag[idx]) v = v + w;
      w = w / 2.0;
      idx--;
    end
    while (k > 0) begin v = v * 2.0; k--; end
    while (k < 0) begin v = v / 2.0; k++; end
    return v;
  endfunction

  function automatic logic [20:0] expectProduct(input logic [7:0] a, input logic [7:0] b);
    real  v;
    int   e;
    int   f;
    logic s;
    if ((a == 8'h80 && b == 8'h00) || (a == 8'h00 && b == 8'h80)) return {2'b11, 19'd0};
    if (a == 8'h80 || b == 8'h80) return {2'b10, 19'd0};
    if (a == 8'h00 || b == 8'h00) return {2'b01, 19'd0};
    s = a[7] ^ b[7];
    v = positMag(a) * positMag(b);
    e = 0;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    f = int'((v - 1.0) * 8192.0);
    return {2'b00, s, 5'(e + 15), 13'(f)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check readies and the
  // presented response just after, then check counters after the rising edge.
  task automatic applyStimulus(input logic av, input logic [7:0] al, input logic [7:0] ar,
                               input logic bv, input logic [7:0] bl, input logic [7:0] br,
                               input logic rr);
    logic        canAcc, gA, gB, eA, eB;
    logic [21:0] exp;
    @(negedge clk);
    aValid = av; aLeft = al; aRight = ar;
    bValid = bv; bLeft = bl; bRight = br;
    respReady = rr;
    #1;
    canAcc = !mFull || rr;
    gA = av && (!bv || mLastId);
    gB = bv && !gA;
    eA = canAcc && gA;
    eB = canAcc && gB;
    checkOutput("a_ready", 32'(aReady), 32'(eA));
    checkOutput("b_ready", 32'(bReady), 32'(eB));
    checkOutput("resp_valid", 32'(respValid), 32'(mFull));
    if (mFull && expQ.size() != 0) begin
      exp = expQ[0];
      checkOutput("resp_id", 32'(respId), 32'(exp[21]));
      checkOutput("resp_result", 32'(respResult), 32'(exp[20:0]));
      if (rr) begin
        void'(expQ.pop_front());
        if (exp[21] == 1'b0) begin
          if (mCntA != CNT_MAX) mCntA = mCntA + 1'b1;
        end else begin
          if (mCntB != CNT_MAX) mCntB = mCntB + 1'b1;
        end
      end
    end
    if (eA || eB) begin
      expQ.push_back({eB, expectProduct(eB ? bl : al, eB ? br : ar)});
      mLastId = eB;
      mFull = 1'b1;
    end else if (mFull && rr) begin
      mFull = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("a_count", 32'(aCount), 32'(mCntA));
    checkOutput("b_count", 32'(bCount), 32'(mCntB));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    aValid = 1'b1; bValid = 1'b1; respReady = 1'b1;
    #1;
    checkOutput("rst_resp_valid", 32'(respValid), 32'd0);
    checkOutput("rst_resp_id", 32'(respId), 32'd0);
    checkOutput("rst_resp_result", 32'(respResult), 32'd0);
    checkOutput("rst_a_count", 32'(aCount), 32'd0);
    checkOutput("rst_b_count", 32'(bCount), 32'd0);
    checkOutput("rst_a_ready", 32'(aReady), 32'd0);
    checkOutput("rst_b_ready", 32'(bReady), 32'd0);
    expQ.delete();
    mFull = 1'b0; mLastId = 1'b1; mCntA = '0; mCntB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_a_ready", 32'(aReady), 32'd0);
    checkOutput("post_rst_b_ready", 32'(bReady), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("post_rst_resp_valid", 32'(respValid), 32'd0);
  endtask

  initial begin
    logic [20:0] held;
    logic        heldId;
    nChecks = 0; nFail = 0;
    rst_n = 1'b0;
    aValid = 1'b0; bValid = 1'b0; respReady = 1'b0;
    aLeft = '0; aRight = '0; bLeft = '0; bRight = '0;
    mFull = 1'b0; mLastId = 1'b1; mCntA = '0; mCntB = '0;

    $display("[TB] reset");
    doReset();

    $display("[TB] single A request, 1.0 * 1.0");
    applyStimulus(1'b1, 8'h40, 8'h40, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("one_valid", 32'(respValid), 32'd1);
    checkOutput("one_id", 32'(respId), 32'd0);
    checkOutput("one_result", 32'(respResult), 32'h1E000);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("one_a_count", 32'(aCount), 32'd1);

    $display("[TB] both requesters every cycle");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'b1);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("rr_a_count", 32'(aCount), 32'd5);
    checkOutput("rr_b_count", 32'(bCount), 32'd4);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'h50, 8'hC8, 1'b0, 8'h00, 8'h00, 1'b0);
    held = respResult;
    heldId = respId;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'b1, 8'($urandom), 8'($urandom), 1'b0);
      checkOutput("hold_result", 32'(respResult), 32'(held));
      checkOutput("hold_id", 32'(respId), 32'(heldId));
    end
    checkOutput("hold_a_count", 32'(aCount), 32'd5);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h3A, 8'h61, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);

    $display("[TB] special operands");
    applyStimulus(1'b1, 8'h80, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("nan_flags", 32'(respResult[20:19]), 32'd3);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h80, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h80, 8'h40, 1'b1);
    checkOutput("inf_flags", 32'(respResult[20:19]), 32'd2);
    applyStimulus(1'b1, 8'h00, 8'h55, 1'b0, 8'h00, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h7F, 8'h7F, 1'b1, 8'h01, 8'h01, 1'b1);
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1, 8'h81, 8'h01, 1'b1);
    applyStimulus(1'b1, 8'h7E, 8'hB3, 1'b1, 8'h6D, 8'h2F, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);

    $display("[TB] random traffic");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    1'($urandom_range(0, 3) != 0));
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);

    $display("[TB] reset while holding a response");
    applyStimulus(1'b1, 8'h48, 8'h48, 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h48, 8'h48, 1'b1, 8'h30, 8'h30, 1'b0);
    doReset();
    applyStimulus(1'b1, 8'h44, 8'h60, 1'b1, 8'h20, 8'h70, 1'b1);
    checkOutput("post_rst_first_id", 32'(respId), 32'd0);

    $display("[TB] counter saturation");
    for (int i = 0; i < 34; i++) begin
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'b0, 8'h00, 8'h00, 1'b1);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1);
    checkOutput("sat_a_count", 32'(aCount), 32'(CNT_MAX));
    checkOutput("sat_b_count", 32'(bCount), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/posit_mult_arbiter_8bit.md
POSIT_MULT_ARBITER_8BIT -- requirements
Module: posit_mult_arbiter_8bit

Interface
REQ-001 Parameter CNT_W, default 16: width of the per-requester completed-operation counters.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 a_valid  input  1  requester A has an operand pair.
REQ-005 a_ready  output  1  requester A operands accepted this cycle.
REQ-006 a_left, a_right  input  8 each  requester A posit operands.
REQ-007 b_valid / b_ready / b_left / b_right  same as REQ-004..006, for requester B.
REQ-008 resp_valid  output  1  resp_* holds a valid product.
REQ-009 resp_ready  input  1  consumer accepts the response this cycle.
REQ-010 resp_id  output  1  response owner: 0 = A, 1 = B.
REQ-011 resp_result  output  21  product: [20:19] flags, [18] sign, [17:13] exponent, [12:0] fraction.
REQ-012 a_count, b_count  output  CNT_W each  responses delivered per requester.

Function
REQ-013 The block SHALL share one combinational 8-bit posit multiplier between requesters A and B; its 21-bit output is captured into the response register.
REQ-014 A transfer SHALL occur on a_valid&a_ready (likewise B), and at most one requester transfers per cycle.
REQ-015 State SHALL be EMPTY (resp_valid=0) or FULL (resp_valid=1); can_accept = EMPTY | (FULL & resp_ready).
REQ-016 Grant SHALL be round-robin: pointer last_id names the last granted requester; with both valid, grant the other one; with one valid, grant it irrespective of pointer.
REQ-017 a_ready SHALL equal can_accept & grant_A, b_ready likewise; ready SHALL be combinational from valid, pointer, state and resp_ready (no valid depends on ready).
REQ-018 On a transfer, resp_result SHALL be loaded with the product of the granted operands, resp_id with the granted index, resp_valid set, last_id updated; latency = 1 cycle.
REQ-019 In FULL without resp_ready, resp_result/resp_id SHALL hold stable and both readies SHALL be 0.
REQ-020 FULL & resp_ready & no transfer SHALL go EMPTY; FULL & resp_ready & transfer SHALL stay FULL with the new product (back-to-back, one result per cycle).
REQ-021 On each response handshake, the counter of resp_id SHALL increment by 1, saturating at all-ones.
REQ-022 Flag bits SHALL pass unmodified from the multiplier (inf*0 gives 2'b11); the arbiter does not filter NaN.
REQ-023 Operands SHALL be sampled only on the transfer cycle; changes on a non-granted requester have no effect.

Reset
REQ-024 While rst_n=0: resp_valid=0, resp_id=0, resp_result=21'h0, last_id=1 (A wins first tie), a_count=b_count=0, state EMPTY.
REQ-025 Reset mid-operation SHALL discard any held response without incrementing counters; a_ready/b_ready SHALL be 0 during reset.
REQ-026 Deassertion SHALL be synchronised by the integrator; the block samples no input in the first cycle after release.

Structure
REQ-027 Shared package SHALL hold the result field positions (FLAG_HI=20, FLAG_LO=19, SIGN=18, EXP_HI=17, EXP_LO=13, FRAC_HI=12) and the ID_A=0 / ID_B=1 constants.
REQ-028 One sub-module: the existing posit_mult_8bit_to_16bit combinational multiplier, instantiated once; arbitration, state and counters live in the top.

Verification
REQ-029 A only, a_left=a_right=8'h40 (1.0), resp_ready=1 -> next cycle resp_valid=1, resp_id=0, resp_result=21'h1E000, a_count=1.
REQ-030 A and B valid every cycle, resp_ready=1 -> resp_id sequence 0,1,0,1..., one response per cycle, counts equal after 8 cycles.
REQ-031 resp_ready=0 for 5 cycles while FULL -> readies 0, resp_result/resp_id stable, counters unchanged; release -> drains, then accepts the next request.
REQ-032 a_left=8'h80 (inf), a_right=8'h00 (zero) -> resp_result[20:19]=2'b11.
REQ-033 Assert rst_n=0 while FULL and resp_ready=0 -> resp_valid=0 immediately, counters 0; after release both valid -> A granted first.
REQ-034 Force a_count to all-ones, complete one more A response -> a_count stays all-ones, b_count unaffected.
